// File: rtl/ball_i2c_tx_sequencer_if.sv
// Byte-level command bus between the ball-state sequencer (master) and the I2C master engine (slave).
interface ball_i2c_tx_sequencer_if;
    logic       o_cmd_valid;
    logic [1:0] o_cmd;
    logic [7:0] o_cmd_data;
    logic       i_cmd_ready;
    logic       i_cmd_done;
    logic       i_nack;

    modport master (
        output o_cmd_valid, o_cmd, o_cmd_data,
        input  i_cmd_ready, i_cmd_done, i_nack
    );

    modport slave (
        input  o_cmd_valid, o_cmd, o_cmd_data,
        output i_cmd_ready, i_cmd_done, i_nack
    );
endinterface

// File: rtl/ball_i2c_tx_sequencer.sv
// Sends one snapshotted ball-state packet (START, 5 WRITEs, STOP) over the I2C command bus,
// with NACK/timeout retry and a single-entry pending request buffer.
module ball_i2c_tx_sequencer #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h42,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned RETRY_GAP  = 100,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ball_send_trigger,
    input  logic [9:0]              i_ball_y,
    input  logic [7:0]              i_ball_vy,
    output logic                    is_transfer,
    ball_i2c_tx_sequencer_if.master cmd_if,
    output logic                    o_send_done,
    output logic                    o_send_fail,
    output logic [1:0]              o_retry_cnt
);
    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_START      = 4'd1;
    localparam logic [3:0] S_WAIT_START = 4'd2;
    localparam logic [3:0] S_WRITE      = 4'd3;
    localparam logic [3:0] S_WAIT_WRITE = 4'd4;
    localparam logic [3:0] S_STOP       = 4'd5;
    localparam logic [3:0] S_WAIT_STOP  = 4'd6;
    localparam logic [3:0] S_BACKOFF    = 4'd7;
    localparam logic [3:0] S_DONE       = 4'd8;
    localparam logic [3:0] S_FAIL       = 4'd9;

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_STOP  = 2'b10;

    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned GAP_W = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RETRY_GAP - 1);

    logic [3:0]       state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic             err_q, err_d;
    logic [1:0]       retry_q, retry_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [9:0]       snap_y_q, snap_y_d;
    logic [7:0]       snap_vy_q, snap_vy_d;
    logic             pend_q, pend_d;
    logic [9:0]       pend_y_q, pend_y_d;
    logic [7:0]       pend_vy_q, pend_vy_d;

    logic [7:0] b1, b2, b3, tx_byte;
    logic       tmo_hit;

    assign b1      = {6'b101100, snap_y_q[9:8]};
    assign b2      = snap_y_q[7:0];
    assign b3      = snap_vy_q;
    assign tmo_hit = (tmo_q == TMO_LAST);

    always_comb begin
        tx_byte = '0;
        case (idx_q)
            3'd0:    tx_byte = {SLAVE_ADDR, 1'b0};
            3'd1:    tx_byte = b1;
            3'd2:    tx_byte = b2;
            3'd3:    tx_byte = b3;
            3'd4:    tx_byte = b1 ^ b2 ^ b3;
            default: tx_byte = '0;
        endcase
    end

    assign is_transfer = (state_q != S_IDLE);
    assign o_send_done = (state_q == S_DONE);
    assign o_send_fail = (state_q == S_FAIL);
    assign o_retry_cnt = retry_q;

    always_comb begin
        cmd_if.o_cmd_valid = 1'b0;
        cmd_if.o_cmd       = CMD_START;
        cmd_if.o_cmd_data  = '0;
        case (state_q)
            S_START: cmd_if.o_cmd_valid = 1'b1;
            S_WRITE: begin
                cmd_if.o_cmd_valid = 1'b1;
                cmd_if.o_cmd       = CMD_WRITE;
                cmd_if.o_cmd_data  = tx_byte;
            end
            S_STOP: begin
                cmd_if.o_cmd_valid = 1'b1;
                cmd_if.o_cmd       = CMD_STOP;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        err_d     = err_q;
        retry_d   = retry_q;
        tmo_d     = tmo_q;
        gap_d     = gap_q;
        snap_y_d  = snap_y_q;
        snap_vy_d = snap_vy_q;
        pend_d    = pend_q;
        pend_y_d  = pend_y_q;
        pend_vy_d = pend_vy_q;

        // Any trigger while busy (including DONE/FAIL) lands in the pending buffer; last one wins.
        if (ball_send_trigger && is_transfer) begin
            pend_d    = 1'b1;
            pend_y_d  = i_ball_y;
            pend_vy_d = i_ball_vy;
        end

        case (state_q)
            S_IDLE: begin
                if (ball_send_trigger) begin
                    snap_y_d  = i_ball_y;
                    snap_vy_d = i_ball_vy;
                    idx_d     = '0;
                    err_d     = 1'b0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (cmd_if.i_cmd_ready) begin
                    tmo_d   = '0;
                    state_d = S_WAIT_START;
                end
            end
            S_WAIT_START: begin
                if (cmd_if.i_cmd_done) begin
                    idx_d   = '0;
                    state_d = S_WRITE;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_STOP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WRITE: begin
                if (cmd_if.i_cmd_ready) begin
                    tmo_d   = '0;
                    state_d = S_WAIT_WRITE;
                end
            end
            S_WAIT_WRITE: begin
                if (cmd_if.i_cmd_done) begin
                    if (cmd_if.i_nack) begin
                        err_d   = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = (idx_q == 3'd4) ? S_STOP : S_WRITE;
                    end
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_STOP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cmd_if.i_cmd_ready) begin
                    tmo_d   = '0;
                    state_d = S_WAIT_STOP;
                end
            end
            S_WAIT_STOP: begin
                if (cmd_if.i_cmd_done || tmo_hit) begin
                    // A STOP timeout counts as an error even on an otherwise clean packet.
                    if (!err_q && cmd_if.i_cmd_done) begin
                        state_d = S_DONE;
                    end else if ({30'd0, retry_q} < MAX_RETRY) begin
                        err_d   = 1'b1;
                        retry_d = retry_q + 2'd1;
                        gap_d   = '0;
                        state_d = S_BACKOFF;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_FAIL;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_BACKOFF: begin
                if (gap_q == GAP_LAST) begin
                    idx_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_START;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_DONE, S_FAIL: begin
                retry_d = '0;
                err_d   = 1'b0;
                if (pend_q || ball_send_trigger) begin
                    snap_y_d  = ball_send_trigger ? i_ball_y  : pend_y_q;
                    snap_vy_d = ball_send_trigger ? i_ball_vy : pend_vy_q;
                    pend_d    = 1'b0;
                    idx_d     = '0;
                    state_d   = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            err_q     <= 1'b0;
            retry_q   <= '0;
            tmo_q     <= '0;
            gap_q     <= '0;
            snap_y_q  <= '0;
            snap_vy_q <= '0;
            pend_q    <= 1'b0;
            pend_y_q  <= '0;
            pend_vy_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            retry_q   <= retry_d;
            tmo_q     <= tmo_d;
            gap_q     <= gap_d;
            snap_y_q  <= snap_y_d;
            snap_vy_q <= snap_vy_d;
            pend_q    <= pend_d;
            pend_y_q  <= pend_y_d;
            pend_vy_q <= pend_vy_d;
        end
    end
endmodule

// File: tb/tb_ball_i2c_tx_sequencer.sv
// Directed bench: a scripted I2C master responder logs every accepted command for comparison.
module tb_ball_i2c_tx_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ball_send_trigger = 1'b0;
    logic [9:0] i_ball_y = '0;
    logic [7:0] i_ball_vy = '0;
    logic       is_transfer, o_send_done, o_send_fail;
    logic [1:0] o_retry_cnt;

    ball_i2c_tx_sequencer_if bus();

    ball_i2c_tx_sequencer #(
        .SLAVE_ADDR(7'h42),
        .MAX_RETRY (3),
        .RETRY_GAP (100),
        .TIMEOUT   (4096)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .ball_send_trigger(ball_send_trigger),
        .i_ball_y         (i_ball_y),
        .i_ball_vy        (i_ball_vy),
        .is_transfer      (is_transfer),
        .cmd_if           (bus),
        .o_send_done      (o_send_done),
        .o_send_fail      (o_send_fail),
        .o_retry_cnt      (o_retry_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0, n_err = 0;
    int unsigned cyc = 0, done_cnt = 0, fail_cnt = 0, busy_drops = 0, data_err = 0;
    int unsigned attempts = 0, widx = 0, rsp_idx = 0, rsp_lat = 0, stall_left = 0;
    int unsigned stop_done_cyc = 0, last_gap = 0, nack_mode = 0;
    logic [1:0]  retry_at_end = '0, rsp_cmd = '0;
    bit          rsp_busy = 0, stall_arm = 0, withhold_start = 0, watch_busy = 0;
    logic [9:0]  log_q[$];
    logic [9:0]  exp_q[$];
    int unsigned log_cyc[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit nack_now(input int unsigned idx);
        return (nack_mode == 1 && attempts == 1 && idx == 2) || (nack_mode == 2 && idx == 0);
    endfunction

    // Called on the negedge before the posedge that accepts the command.
    task automatic accept();
        log_q.push_back({bus.o_cmd, bus.o_cmd_data});
        log_cyc.push_back(cyc);
        if (bus.o_cmd == 2'b00) begin
            attempts++;
            widx = 0;
            if (stop_done_cyc != 0) last_gap = cyc - stop_done_cyc;
        end
        if (bus.o_cmd == 2'b01) begin
            rsp_idx = widx;
            widx++;
        end
        rsp_cmd  = bus.o_cmd;
        rsp_busy = 1;
        rsp_lat  = 2;
    endtask

    initial begin
        bus.i_cmd_ready = 1'b1;
        bus.i_cmd_done  = 1'b0;
        bus.i_nack      = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            bus.i_cmd_done = 1'b0;
            bus.i_nack     = 1'b0;
            if (bus.o_cmd != 2'b01 && bus.o_cmd_data != 8'h00) data_err++;
            if (o_send_done) begin done_cnt++; retry_at_end = o_retry_cnt; end
            if (o_send_fail) begin fail_cnt++; retry_at_end = o_retry_cnt; end
            if (watch_busy && done_cnt < 2 && !is_transfer) busy_drops++;
            if (stall_left > 0) begin
                check_eq("stall_hold", {bus.o_cmd_valid, bus.o_cmd, bus.o_cmd_data}, {1'b1, 2'b01, 8'h84});
                stall_left--;
                if (stall_left == 0) begin
                    bus.i_cmd_ready = 1'b1;
                    accept();
                end
            end else if (rsp_busy) begin
                if (rsp_lat > 0) rsp_lat--;
                else begin
                    rsp_busy = 0;
                    if (rsp_cmd == 2'b00 && withhold_start) withhold_start = 0;
                    else begin
                        bus.i_cmd_done = 1'b1;
                        if (rsp_cmd == 2'b01) bus.i_nack = nack_now(rsp_idx);
                        if (rsp_cmd == 2'b10) stop_done_cyc = cyc;
                    end
                end
            end else if (bus.o_cmd_valid) begin
                if (stall_arm && bus.o_cmd == 2'b01) begin
                    stall_arm       = 0;
                    bus.i_cmd_ready = 1'b0;
                    stall_left      = 10;
                    check_eq("stall_hold", {bus.o_cmd_valid, bus.o_cmd, bus.o_cmd_data}, {1'b1, 2'b01, 8'h84});
                end else begin
                    accept();
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_trig(input logic [9:0] y, input logic [7:0] vy);
        ball_send_trigger = 1'b1;
        i_ball_y          = y;
        i_ball_vy         = vy;
        step();
        ball_send_trigger = 1'b0;
    endtask

    task automatic clear_stats();
        done_cnt = 0; fail_cnt = 0; busy_drops = 0; attempts = 0; widx = 0;
        stop_done_cyc = 0; last_gap = 0; nack_mode = 0; retry_at_end = '0;
        rsp_busy = 0; stall_arm = 0; stall_left = 0; withhold_start = 0; watch_busy = 0;
        bus.i_cmd_ready = 1'b1;
        log_q.delete(); log_cyc.delete(); exp_q.delete();
    endtask

    task automatic wait_pulses(input string tag, input int unsigned n, input int unsigned budget);
        for (int unsigned i = 0; i < budget; i++) begin
            if (done_cnt + fail_cnt >= n) break;
            step();
        end
        check_eq({tag, "_end"}, done_cnt + fail_cnt, n);
        step();
    endtask

    task automatic push_pkt(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
        exp_q.push_back(10'h000);
        exp_q.push_back(10'h184);
        exp_q.push_back({2'b01, b1});
        exp_q.push_back({2'b01, b2});
        exp_q.push_back({2'b01, b3});
        exp_q.push_back({2'b01, b4});
        exp_q.push_back(10'h200);
    endtask

    task automatic check_log(input string tag);
        check_eq({tag, "_len"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check_eq($sformatf("%s[%0d]", tag, i), log_q[i], exp_q[i]);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq(tag, {is_transfer, bus.o_cmd_valid, bus.o_cmd, bus.o_cmd_data, o_send_done, o_send_fail, o_retry_cnt}, '0);
    endtask

    initial begin
        int unsigned nlog;
        bit found;

        step(); step();
        check_idle_outputs("reset_outputs");
        reset = 1'b0;
        step();

        // Basic packet
        clear_stats();
        ball_send_trigger = 1'b1; i_ball_y = 10'h2A5; i_ball_vy = 8'h7F;
        check_eq("busy_at_trigger", is_transfer, 1'b0);
        step();
        ball_send_trigger = 1'b0;
        check_eq("busy_after_trigger", is_transfer, 1'b1);
        wait_pulses("basic", 1, 300);
        push_pkt(8'hB2, 8'hA5, 8'h7F, 8'h68);
        check_log("basic_log");
        check_eq("basic_done", done_cnt, 1);
        check_eq("basic_fail", fail_cnt, 0);
        check_eq("basic_busy_end", is_transfer, 1'b0);
        check_eq("basic_retry", o_retry_cnt, 2'd0);

        // Ready stall on the first WRITE
        clear_stats();
        stall_arm = 1;
        pulse_trig(10'h2A5, 8'h7F);
        wait_pulses("stall", 1, 300);
        push_pkt(8'hB2, 8'hA5, 8'h7F, 8'h68);
        check_log("stall_log");
        check_eq("stall_done", done_cnt, 1);

        // NACK on byte index 2 of first attempt; the same bytes are resent
        clear_stats();
        nack_mode = 1;
        pulse_trig(10'h2A5, 8'h7F);
        wait_pulses("nack1", 1, 1000);
        exp_q.push_back(10'h000); exp_q.push_back(10'h184); exp_q.push_back(10'h1B2);
        exp_q.push_back(10'h1A5); exp_q.push_back(10'h200);
        push_pkt(8'hB2, 8'hA5, 8'h7F, 8'h68);
        check_log("nack1_log");
        check_eq("nack1_gap", last_gap, 101);
        check_eq("nack1_retry_at_done", retry_at_end, 2'd1);
        check_eq("nack1_attempts", attempts, 2);
        check_eq("nack1_done", done_cnt, 1);
        check_eq("nack1_retry_end", o_retry_cnt, 2'd0);

        // NACK every attempt: 4 attempts then FAIL
        clear_stats();
        nack_mode = 2;
        pulse_trig(10'h2A5, 8'h7F);
        wait_pulses("nackall", 1, 2000);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(10'h000); exp_q.push_back(10'h184); exp_q.push_back(10'h200);
        end
        check_log("nackall_log");
        check_eq("nackall_attempts", attempts, 4);
        check_eq("nackall_fail", fail_cnt, 1);
        check_eq("nackall_done", done_cnt, 0);
        check_eq("nackall_retry_at_fail", retry_at_end, 2'd3);
        check_eq("nackall_retry_end", o_retry_cnt, 2'd0);
        check_eq("nackall_busy_end", is_transfer, 1'b0);

        // Pending request: Y=5 then Y=9 while busy, last one wins
        clear_stats();
        pulse_trig(10'h100, 8'h10);
        watch_busy = 1;
        repeat (4) step();
        pulse_trig(10'h005, 8'h01);
        repeat (3) step();
        pulse_trig(10'h009, 8'h22);
        wait_pulses("pend", 2, 600);
        watch_busy = 0;
        push_pkt(8'hB1, 8'h00, 8'h10, 8'hA1);
        push_pkt(8'hB0, 8'h09, 8'h22, 8'h9B);
        check_log("pend_log");
        check_eq("pend_busy_drops", busy_drops, 0);
        check_eq("pend_done", done_cnt, 2);
        check_eq("pend_busy_end", is_transfer, 1'b0);

        // START never completes: timeout, STOP, retry
        clear_stats();
        withhold_start = 1;
        pulse_trig(10'h2A5, 8'h7F);
        wait_pulses("tmo", 1, 5000);
        exp_q.push_back(10'h000); exp_q.push_back(10'h200);
        push_pkt(8'hB2, 8'hA5, 8'h7F, 8'h68);
        check_log("tmo_log");
        // START is logged one negedge before its accepting edge; WAIT_START then lasts 4096 cycles.
        if (log_cyc.size() >= 2) check_eq("tmo_delay", log_cyc[1] - log_cyc[0], 4097);
        else check_eq("tmo_delay_missing", log_cyc.size(), 2);
        check_eq("tmo_retry_at_done", retry_at_end, 2'd1);
        check_eq("tmo_done", done_cnt, 1);

        // Reset mid-WRITE
        clear_stats();
        pulse_trig(10'h2A5, 8'h7F);
        found = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (bus.o_cmd_valid && bus.o_cmd == 2'b01) begin found = 1; break; end
        end
        check_eq("rst_reach_write", found, 1'b1);
        reset = 1'b1;
        #1;
        check_idle_outputs("rst_mid_write");
        step(); step();
        reset = 1'b0;
        nlog = log_q.size();
        repeat (20) step();
        check_eq("rst_no_more_cmds", log_q.size(), nlog);
        check_eq("rst_idle", {is_transfer, bus.o_cmd_valid}, 2'b00);

        check_eq("data_zero_unless_write", data_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
